// File: rtl/riscv_unified_mem_ctrl_pkg.sv
// Package riscv_mem_pkg: shared types and constants for the unified memory
// controller.
//   mem_size_e   access size code as carried on req_size (B/H/W/D)
//   mem_state_e  controller FSM states
//   LATENCY_MIN/LATENCY_MAX  legal bounds for the access latency parameter
package riscv_mem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_e;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 15;

  function automatic logic latency_legal(input int unsigned lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/riscv_unified_mem_ctrl_lane_align.sv
// riscv_mem_lane_align: combinational byte-lane steering for one storage word.
//   off_i       byte lane offset of the access inside the word
//   size_i      access size (B/H/W/D); sizes wider than the word are clamped
//   unsigned_i  1 = zero-extend load data, 0 = sign-extend
//   raw_i       word read from the backing array
//   wdata_i     right-aligned store data
//   ld_data_o   extracted and extended load data
//   st_be_o     byte-enable mask for the store
//   st_data_o   store data shifted into its lane
module riscv_mem_lane_align
  import riscv_mem_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  localparam int unsigned NB = XLEN / 8,
  localparam int unsigned OFF_W = $clog2(NB)
) (
  input  logic [OFF_W-1:0] off_i,
  input  mem_size_e        size_i,
  input  logic             unsigned_i,
  input  logic [XLEN-1:0]  raw_i,
  input  logic [XLEN-1:0]  wdata_i,
  output logic [XLEN-1:0]  ld_data_o,
  output logic [NB-1:0]    st_be_o,
  output logic [XLEN-1:0]  st_data_o
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            sign;
  int unsigned     nbytes;

  always_comb begin
    nbytes = 32'd1 << size_i;
    if (nbytes > NB) nbytes = NB;
    shifted = raw_i >> {off_i, 3'b000};
    keep    = '0;
    sign    = 1'b0;
    st_be_o = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i < nbytes) keep[i*8 +: 8] = 8'hFF;
      // Sign bit is the MSB of the most significant accessed byte.
      if (i == nbytes - 1) sign = shifted[i*8 + 7];
      if ((i >= 32'(off_i)) && (i < 32'(off_i) + nbytes)) st_be_o[i] = 1'b1;
    end
    sign      = sign & ~unsigned_i;
    ld_data_o = (shifted & keep) | (~keep & {XLEN{sign}});
    st_data_o = wdata_i << {off_i, 3'b000};
  end

endmodule

// File: rtl/riscv_unified_mem_ctrl.sv
// riscv_unified_mem_ctrl: unified instruction/data memory with a valid/ready
// request handshake, fixed LATENCY wait states, sized loads/stores with
// sign/zero extension, a program-load override write and error reporting.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned access -> rsp_err)
// otherwise low address bits are forced to natural alignment.
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   req_valid / req_ready    request handshake, accepted on valid && ready
//   req_we, req_iord         store select, 0=fetch / 1=data access
//   req_override             program-load 32-bit write of req_wdata[31:0]
//   req_size, req_unsigned   access size (B/H/W/D), zero-extend select
//   req_addr, req_wdata      byte address, right-aligned store data
//   rsp_valid                one-cycle response strobe
//   rsp_rdata, rsp_err       load/fetch result and fault flag
module riscv_unified_mem_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic            req_iord,
  input  logic            req_override,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned NB       = XLEN / 8;
  localparam int unsigned OFF_W    = $clog2(NB);
  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] BYTE_CAP = XLEN'(DEPTH_WORDS * NB);

  if (!latency_legal(LATENCY)) begin : g_bad_latency
    $error("riscv_unified_mem_ctrl: LATENCY must be within 1..15");
  end

  // Request decode (combinational, from the live request inputs)
  mem_size_e       size_dec;
  logic            uns_dec;
  logic            we_dec;
  logic [XLEN-1:0] wdata_dec;
  logic [XLEN-1:0] addr_dec;
  logic [XLEN-1:0] align_mask;
  logic            err_dec;

  always_comb begin
    size_dec  = mem_size_e'(req_size);
    uns_dec   = req_unsigned;
    we_dec    = req_we;
    wdata_dec = req_wdata;
    addr_dec  = req_addr;
    if (req_override) begin
      // Program load: word store at the word-aligned address, never faults on alignment.
      size_dec  = SZ_W;
      uns_dec   = 1'b1;
      we_dec    = 1'b1;
      wdata_dec = XLEN'(req_wdata[31:0]);
      addr_dec  = req_addr & ~XLEN'(3);
    end else if (!req_iord) begin
      size_dec = SZ_W;
      uns_dec  = 1'b1;
      we_dec   = 1'b0;
    end
    if ((XLEN == 32) && (size_dec == SZ_D)) size_dec = SZ_W;
    align_mask = XLEN'((32'd1 << size_dec) - 32'd1);
`ifdef MEM_MISALIGN_TRAP_EN
    err_dec = (addr_dec >= BYTE_CAP) || ((addr_dec & align_mask) != '0);
`else
    addr_dec = addr_dec & ~align_mask;
    err_dec  = (addr_dec >= BYTE_CAP);
`endif
  end

  // Controller state and captured request
  mem_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  mem_size_e        size_q, size_d;
  logic             uns_q, uns_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic             rerr_q, rerr_d;

  logic [XLEN-1:0]  mem_q [DEPTH_WORDS];
  logic [XLEN-1:0]  raw_word;
  logic [XLEN-1:0]  ld_data;
  logic [NB-1:0]    st_be;
  logic [XLEN-1:0]  st_data;
  logic             commit;

  assign raw_word = mem_q[idx_q];
  assign commit   = (state_q == WAIT) && (cnt_q == '0);

  riscv_mem_lane_align #(.XLEN(XLEN)) u_lane_align (
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .raw_i      (raw_word),
    .wdata_i    (wdata_q),
    .ld_data_o  (ld_data),
    .st_be_o    (st_be),
    .st_data_o  (st_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
          size_d  = size_dec;
          uns_d   = uns_dec;
          we_d    = we_dec;
          err_d   = err_dec;
          idx_d   = addr_dec[OFF_W +: IDX_W];
          off_d   = addr_dec[OFF_W-1:0];
          wdata_d = wdata_dec;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rdata_d = (err_q || we_q) ? '0 : ld_data;
          rerr_d  = err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Backing array is not reset; an async reset forces IDLE so no commit fires.
  always_ff @(posedge clk) begin
    if (commit && we_q && !err_q) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (st_be[i]) mem_q[idx_q][i*8 +: 8] <= st_data[i*8 +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

endmodule

// File: tb/tb_riscv_unified_mem_ctrl.sv
module tb_riscv_unified_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_iord = 1'b0;
  logic        req_override = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_unified_mem_ctrl #(.XLEN(64), .DEPTH_WORDS(512), .LATENCY(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_iord     (req_iord),
    .req_override (req_override),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  // Issue one request and collect its response.
  // ncyc = edges from acceptance to the first sample showing rsp_valid (-1 on timeout).
  task automatic do_req(input logic we, input logic iord, input logic ovr,
                        input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        output logic [63:0] rdata, output logic err, output int ncyc,
                        output logic busy_ok, output logic ready_after, output logic pulse_ok);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_iord = iord; req_override = ovr;
    req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_override = 1'b0;
    ncyc = -1; busy_ok = 1'b1; rdata = '0; err = 1'b0;
    if (req_ready !== 1'b0) busy_ok = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (req_ready !== 1'b0) busy_ok = 1'b0;
      if (rsp_valid === 1'b1) begin
        ncyc = i; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
    @(posedge clk); #1;
    ready_after = req_ready;
    pulse_ok = (rsp_valid === 1'b0);
  endtask

  logic [63:0] rd;
  logic        er, busy, rdy, pulse;
  int          n;

  task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", rsp_err); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    do_req(1, 1, 0, 2'd3, 0, 64'd24, 64'h64, rd, er, n, busy, rdy, pulse);
    checks++; if (n !== 2) begin errors++; $display("FAIL sd_latency: got %0d expected 2", n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sd_ready_low: got %b expected 1", busy); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sd_ready_return: got %b expected 1", rdy); end
    checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL sd_one_cycle_valid: got %b expected 1", pulse); end
    checks++; if (rd !== 64'h0 || er !== 1'b0) begin errors++; $display("FAIL sd_rsp: got %h/%b expected 0/0", rd, er); end
    do_req(0, 1, 0, 2'd3, 0, 64'd24, 64'h0, rd, er, n, busy, rdy, pulse);
    checks++; if (rd !== 64'h64 || er !== 1'b0) begin errors++; $display("FAIL ld24: got %h/%b expected 64/0", rd, er); end
  endtask

  task automatic test_override_fetch();
    do_req(1, 1, 0, 2'd3, 0, 64'd0, 64'h0, rd, er, n, busy, rdy, pulse);
    do_req(0, 1, 1, 2'd0, 0, 64'd0, 64'hFFFF_FFFF_0057_8833, rd, er, n, busy, rdy, pulse);
    checks++; if (rd !== 64'h0 || er !== 1'b0) begin errors++; $display("FAIL ovr_rsp: got %h/%b expected 0/0", rd, er); end
    do_req(0, 0, 0, 2'd0, 0, 64'd0, 64'h0, rd, er, n, busy, rdy, pulse);
    checks++; if (rd !== 64'h0000_0000_0057_8833 || er !== 1'b0) begin errors++; $display("FAIL fetch0: got %h/%b expected 578833/0", rd, er); end
  endtask

  task automatic test_byte_half();
    do_req(1, 1, 0, 2'd0, 0, 64'd27, 64'h80, rd, er, n, busy, rdy, pulse);
    do_req(0, 1, 0, 2'd0, 0, 64'd27, 64'h0, rd, er, n, busy, rdy, pulse);
    checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb27: got %h expected ffffffffffffff80", rd); end
    do_req(0, 1, 0, 2'd0, 1, 64'd27, 64'h0, rd, er, n, busy, rdy, pulse);
    checks++; if (rd !== 64'h80) begin errors++; $display("FAIL lbu27: got %h expected 80", rd); end
    do_req(0, 1, 0, 2'd3, 0, 64'd24, 64'h0, rd, er, n, busy, rdy, pulse);
    checks++; if (rd !== 64'h0000_0000_8000_0064) begin errors++; $display("FAIL ld24_after_sb: got %h expected 80000064", rd); end
    do_req(0, 1, 0, 2'd1, 0, 64'd26, 64'h0, rd, er, n, busy, rdy, pulse);
    checks++; if (rd !== 64'hFFFF_FFFF_FFFF_8000) begin errors++; $display("FAIL lh26: got %h expected ffffffffffff8000", rd); end
    do_req(0, 1, 0, 2'd1, 1, 64'd26, 64'h0, rd, er, n, busy, rdy, pulse);
    checks++; if (rd !== 64'h8000) begin errors++; $display("FAIL lhu26: got %h expected 8000", rd); end
  endtask

  task automatic test_misalign();
    do_req(0, 1, 0, 2'd2, 0, 64'd26, 64'h0, rd, er, n, busy, rdy, pulse);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if (rd !== 64'h0 || er !== 1'b1) begin errors++; $display("FAIL lw26_trap: got %h/%b expected 0/1", rd, er); end
`else
    checks++; if (rd !== 64'hFFFF_FFFF_8000_0064 || er !== 1'b0) begin errors++; $display("FAIL lw26_align: got %h/%b expected ffffffff80000064/0", rd, er); end
`endif
  endtask

  task automatic test_range();
    do_req(1, 1, 0, 2'd3, 0, 64'd4096, 64'hDEAD_BEEF, rd, er, n, busy, rdy, pulse);
    checks++; if (rd !== 64'h0 || er !== 1'b1) begin errors++; $display("FAIL sd4096: got %h/%b expected 0/1", rd, er); end
    do_req(0, 1, 0, 2'd3, 0, 64'd0, 64'h0, rd, er, n, busy, rdy, pulse);
    checks++; if (rd !== 64'h0000_0000_0057_8833 || er !== 1'b0) begin errors++; $display("FAIL ld0_after_oor: got %h/%b expected 578833/0", rd, er); end
    do_req(1, 1, 0, 2'd3, 0, 64'd4088, 64'h1122_3344_5566_7788, rd, er, n, busy, rdy, pulse);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sd4088_err: got %b expected 0", er); end
    do_req(0, 1, 0, 2'd3, 0, 64'd4088, 64'h0, rd, er, n, busy, rdy, pulse);
    checks++; if (rd !== 64'h1122_3344_5566_7788 || er !== 1'b0) begin errors++; $display("FAIL ld4088: got %h/%b expected 1122334455667788/0", rd, er); end
  endtask

  task automatic test_reset_mid_op();
    logic seen;
    do_req(1, 1, 0, 2'd3, 0, 64'd32, 64'h1234, rd, er, n, busy, rdy, pulse);
    do_req(0, 1, 0, 2'd3, 0, 64'd32, 64'h0, rd, er, n, busy, rdy, pulse);
    checks++; if (rd !== 64'h1234) begin errors++; $display("FAIL ld32_pre: got %h expected 1234", rd); end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_iord = 1'b1; req_size = 2'd3;
    req_unsigned = 1'b0; req_addr = 64'd32; req_wdata = 64'hAA;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_async: got ready=%b valid=%b expected 1/0", req_ready, rsp_valid); end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_rsp: got %b expected 0", seen); end
    checks++; if (req_ready !== 1'b1 || rsp_rdata !== 64'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rst_outputs: got %b/%h/%b expected 1/0/0", req_ready, rsp_rdata, rsp_err); end
    do_req(0, 1, 0, 2'd3, 0, 64'd32, 64'h0, rd, er, n, busy, rdy, pulse);
    checks++; if (rd !== 64'h1234 || er !== 1'b0) begin errors++; $display("FAIL ld32_post: got %h/%b expected 1234/0", rd, er); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_override_fetch();
    test_byte_half();
    test_misalign();
    test_range();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
